alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer placed in front of the team's 16-bit combinational ALU (`ALUmod`). It accepts one ALU request at a time through a valid/ready handshake and sequences the ALU over one or more passes. Multi-bit shifts iterate the 1-bit shifter, and add-with-carry uses two passes with the stored carry. It owns the processor status flags register (C,L,F,Z,N) and returns the result through a valid/ready response port.

## Interface
Parameters:
- `WIDTH`, 16: datapath width; fixed to the ALU width.
- `SHW`, 4: shift-count width; count = `req_b[SHW-1:0]`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_opcode`  in  4: ALU opcode.
- `req_opext`  in  4: ALU opcode extension.
- `req_a`  in  16: operand A.
- `req_b`  in  16: operand B, or shift count for shift ops.
- `rsp_valid`  out  1: result held.
- `rsp_ready`  in  1: consumer takes result.
- `rsp_data`  out  16: result.
- `psr`  out  5: flags register {C,L,F,Z,N}, bit 4 down to 0.
- `alu_a`, `alu_b`  out  16: ALU operand drives.
- `alu_opcode`, `alu_opext`  out  4: ALU operation drives.
- `alu_s`  in  16: ALU result.
- `alu_flags`  in  5: ALU CLFZN.

## Operation
- States: IDLE, EXEC, CARRY, SHIFT, DONE.
- IDLE:
  - `req_ready=1`.
  - On `req_valid&req_ready`, latch opcode, opext, A, B. Load count = B[3:0]. Go to EXEC, or to SHIFT when the op is a shift with count≠0.
- Shift ops: LSH, LSHI, RSH, RSHI, ALSH, ARSH.
  - SHIFT drives the ALU with the latched op and `alu_a` = accumulator (initially A).
  - Each cycle: accumulator ← `alu_s`, count−1. Exit to DONE when count reaches 1 on that cycle.
  - Count 0: go to EXEC with the ALU driven as MOV (0000_1101); result = A.
- Add-with-carry: ADDC 0000_0111, ADDCI 0111_xxxx, ADDCU 1010_0101, ADDCUI 1010_0110.
  - EXEC always drives ADDU (0000_0110) with A, B.
  - If `psr[4]=0`: capture and go to DONE.
  - If `psr[4]=1`: capture s1, c1, go to CARRY. CARRY drives ADDU(s1, 1) and captures s2, c2.
  - Final C = c1|c2; Z = (result==0).
  - F (signed variants only) is computed by the block from the original operands: (~A15&~B15&R15)|(A15&B15&~R15).
  - L and N are 0.
- All other ops: one EXEC pass with the latched opcode/opext; result and flags taken from the ALU.
- PSR write:
  - Written on the cycle that captures the final result.
  - MOV (0000_1101), MOVI (1101_xxxx) and NOP (0000_0000) leave `psr` unchanged.
  - All other ops load the flags described above.
- DONE:
  - `rsp_valid=1`; `rsp_data` stable until `rsp_valid&rsp_ready`, then return to IDLE.
  - `req_ready=0` in every state except IDLE; no accept in the same cycle as the response handshake.
- Unused ALU drives: in IDLE and DONE, `alu_opcode`/`alu_opext`=0 and operands are 0.

## Timing
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_data=0`, `psr=0`, ALU drives 0, accumulator and count 0.
- Latency from the accept edge T to `rsp_valid` high:
  - single pass: T+2
  - add-with-carry with C=1: T+3
  - shift by n≥1: T+1+n (max T+16)
  - shift by 0: T+2
- The ALU path is combinational within one cycle. The block registers every pass result; there is no combinational path from `req_*` to `rsp_*`.
- Back-to-back requests: minimum issue interval = latency+1 (IDLE cycle).
- Reset asserted mid-operation: immediate abort, no response, `psr` cleared.
- `rsp_ready` held low: block stays in DONE indefinitely with `rsp_data` and `psr` constant.

## Structure
- Shared package `alu_pkg`:
  - opcode/opext constants for every ALU operation
  - flag bit indices C=4, L=3, F=2, Z=1, N=0
  - `state_t` enum
  - helper functions `is_shift`, `is_addc`, `is_signed_addc`, `writes_psr`
- One sub-module is natural: the sequencer is instantiated beside `ALUmod` in the execute stage. The `alu_*` ports connect directly, so `ALUmod` is not instantiated inside this block.

## Test plan
- Reset, then ADD 0x7FFF+0x0001 -> `rsp_data`=0x8000 at T+2; ALU flags loaded into `psr`; `req_ready` low T+1..T+2.
- ADDU 0xFFFF+0x0001, then ADDC 0x0001+0x0002 -> first: `rsp_data`=0x0000, `psr` C=1, Z=1; second: `rsp_data`=0x0004 at T+3, C=0, Z=0.
- LSHI A=0x0001, count=15 -> `rsp_data`=0x8000 at T+16; count=0 -> `rsp_data`=0x0001 at T+2.
- MOV 0x1234 after a flag-setting op -> `rsp_data`=0x1234; `psr` unchanged.
- Hold `rsp_ready`=0 for 5 cycles with `req_valid`=1 -> `rsp_data` stable, no second accept; accept only the cycle after the handshake.
- Assert `reset_n` low during SHIFT of count 10 -> `rsp_valid`=0, `psr`=0, `req_ready`=1 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings, flag bit positions, sequencer states and opcode decode helpers.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OPW    = 4;
    localparam int unsigned FLW    = 5;

    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_L = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    // Primary opcodes
    localparam logic [OPW-1:0] OPC_REG   = 4'b0000;
    localparam logic [OPW-1:0] OPC_ADDI  = 4'b0101;
    localparam logic [OPW-1:0] OPC_ADDUI = 4'b0110;
    localparam logic [OPW-1:0] OPC_ADDCI = 4'b0111;
    localparam logic [OPW-1:0] OPC_SHIFT = 4'b1000;
    localparam logic [OPW-1:0] OPC_ADDCU = 4'b1010;
    localparam logic [OPW-1:0] OPC_MOVI  = 4'b1101;

    // Extensions under OPC_REG
    localparam logic [OPW-1:0] EXT_NOP  = 4'b0000;
    localparam logic [OPW-1:0] EXT_AND  = 4'b0001;
    localparam logic [OPW-1:0] EXT_OR   = 4'b0010;
    localparam logic [OPW-1:0] EXT_XOR  = 4'b0011;
    localparam logic [OPW-1:0] EXT_ADD  = 4'b0101;
    localparam logic [OPW-1:0] EXT_ADDU = 4'b0110;
    localparam logic [OPW-1:0] EXT_ADDC = 4'b0111;
    localparam logic [OPW-1:0] EXT_SUB  = 4'b1001;
    localparam logic [OPW-1:0] EXT_CMP  = 4'b1011;
    localparam logic [OPW-1:0] EXT_MOV  = 4'b1101;

    // Extensions under OPC_SHIFT
    localparam logic [OPW-1:0] EXT_LSHI = 4'b0000;
    localparam logic [OPW-1:0] EXT_RSHI = 4'b0001;
    localparam logic [OPW-1:0] EXT_LSH  = 4'b0100;
    localparam logic [OPW-1:0] EXT_RSH  = 4'b0101;
    localparam logic [OPW-1:0] EXT_ALSH = 4'b0110;
    localparam logic [OPW-1:0] EXT_ARSH = 4'b0111;

    // Extensions under OPC_ADDCU
    localparam logic [OPW-1:0] EXT_ADDCU  = 4'b0101;
    localparam logic [OPW-1:0] EXT_ADDCUI = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_CARRY = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic is_shift(input logic [OPW-1:0] op, input logic [OPW-1:0] ext);
        return (op == OPC_SHIFT) &&
               (ext inside {EXT_LSHI, EXT_RSHI, EXT_LSH, EXT_RSH, EXT_ALSH, EXT_ARSH});
    endfunction

    function automatic logic is_signed_addc(input logic [OPW-1:0] op, input logic [OPW-1:0] ext);
        return ((op == OPC_REG) && (ext == EXT_ADDC)) || (op == OPC_ADDCI);
    endfunction

    function automatic logic is_addc(input logic [OPW-1:0] op, input logic [OPW-1:0] ext);
        return is_signed_addc(op, ext) ||
               ((op == OPC_ADDCU) && ((ext == EXT_ADDCU) || (ext == EXT_ADDCUI)));
    endfunction

    function automatic logic writes_psr(input logic [OPW-1:0] op, input logic [OPW-1:0] ext);
        return !(((op == OPC_REG) && ((ext == EXT_MOV) || (ext == EXT_NOP))) || (op == OPC_MOVI));
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between the issuing stage and the ALU sequencer.
interface alu_seq_ctrl_if;

    logic                        req_valid;
    logic                        req_ready;
    logic [alu_pkg::OPW-1:0]     req_opcode;
    logic [alu_pkg::OPW-1:0]     req_opext;
    logic [alu_pkg::DATA_W-1:0]  req_a;
    logic [alu_pkg::DATA_W-1:0]  req_b;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [alu_pkg::DATA_W-1:0]  rsp_data;

    modport master (
        output req_valid, req_opcode, req_opext, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_opcode, req_opext, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer in front of the combinational ALU: iterated shifts, two-pass
// add-with-carry, PSR ownership and a registered valid/ready response.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned SHW   = CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_seq_ctrl_if.slave    bus,
    output logic [FLW-1:0]   psr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    output logic [OPW-1:0]   alu_opext,
    input  logic [WIDTH-1:0] alu_s,
    input  logic [FLW-1:0]   alu_flags
);

    state_t           r_state;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [FLW-1:0]   r_psr;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_opcode;
    logic [OPW-1:0]   r_alu_opext;
    logic [OPW-1:0]   r_op;
    logic [OPW-1:0]   r_ext;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_c1;
    logic [SHW-1:0]   r_cnt;

    logic             w_ovf;
    logic [FLW-1:0]   w_addc_psr;

    // r_c1 is cleared on accept, so this is c1|c2 in CARRY and the plain carry in EXEC
    always_comb begin
        w_ovf = is_signed_addc(r_op, r_ext) &
                ((~r_a_msb & ~r_b_msb & alu_s[WIDTH-1]) | (r_a_msb & r_b_msb & ~alu_s[WIDTH-1]));
        w_addc_psr         = '0;
        w_addc_psr[FLAG_C] = alu_flags[FLAG_C] | r_c1;
        w_addc_psr[FLAG_F] = w_ovf;
        w_addc_psr[FLAG_Z] = (alu_s == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_psr        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_alu_opext  <= '0;
            r_op         <= '0;
            r_ext        <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_c1         <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op         <= bus.req_opcode;
                        r_ext        <= bus.req_opext;
                        r_a_msb      <= bus.req_a[WIDTH-1];
                        r_b_msb      <= bus.req_b[WIDTH-1];
                        r_cnt        <= bus.req_b[SHW-1:0];
                        r_c1         <= 1'b0;
                        r_req_ready  <= 1'b0;
                        r_alu_a      <= bus.req_a;
                        r_alu_b      <= bus.req_b;
                        r_alu_opcode <= bus.req_opcode;
                        r_alu_opext  <= bus.req_opext;
                        r_state      <= S_EXEC;
                        // Zero-count shifts collapse to a single MOV pass of A
                        if (is_shift(bus.req_opcode, bus.req_opext)) begin
                            if (bus.req_b[SHW-1:0] != '0) begin
                                r_state <= S_SHIFT;
                            end else begin
                                r_alu_opcode <= OPC_REG;
                                r_alu_opext  <= EXT_MOV;
                            end
                        end else if (is_addc(bus.req_opcode, bus.req_opext)) begin
                            r_alu_opcode <= OPC_REG;
                            r_alu_opext  <= EXT_ADDU;
                        end
                    end
                end

                S_EXEC: begin
                    if (is_addc(r_op, r_ext) && r_psr[FLAG_C]) begin
                        r_c1    <= alu_flags[FLAG_C];
                        r_alu_a <= alu_s;
                        r_alu_b <= WIDTH'(1);
                        r_state <= S_CARRY;
                    end else begin
                        r_rsp_data <= alu_s;
                        if (is_addc(r_op, r_ext)) begin
                            r_psr <= w_addc_psr;
                        end else if (writes_psr(r_op, r_ext)) begin
                            r_psr <= alu_flags;
                        end
                        r_alu_a      <= '0;
                        r_alu_b      <= '0;
                        r_alu_opcode <= '0;
                        r_alu_opext  <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end

                S_CARRY: begin
                    r_rsp_data   <= alu_s;
                    r_psr        <= w_addc_psr;
                    r_alu_a      <= '0;
                    r_alu_b      <= '0;
                    r_alu_opcode <= '0;
                    r_alu_opext  <= '0;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_DONE;
                end

                S_SHIFT: begin
                    // The ALU A operand register doubles as the shift accumulator
                    r_alu_a <= alu_s;
                    r_cnt   <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_rsp_data <= alu_s;
                        if (writes_psr(r_op, r_ext)) begin
                            r_psr <= alu_flags;
                        end
                        r_alu_a      <= '0;
                        r_alu_b      <= '0;
                        r_alu_opcode <= '0;
                        r_alu_opext  <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign psr           = r_psr;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_opcode    = r_alu_opcode;
    assign alu_opext     = r_alu_opext;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU on the alu_* ports.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  psr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_s;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_opext;
    logic [4:0]  alu_flags;
    logic [16:0] m_sum;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl_if bus();

    alu_seq_ctrl #(.WIDTH(16), .SHW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .psr        (psr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_opext  (alu_opext),
        .alu_s      (alu_s),
        .alu_flags  (alu_flags)
    );

    // Behavioural ALU, flags ordered {C,L,F,Z,N}
    assign m_sum = {1'b0, alu_a} + {1'b0, alu_b};
    always_comb begin
        alu_s     = 16'h0000;
        alu_flags = 5'b00000;
        casez ({alu_opcode, alu_opext})
            8'b0000_0101, 8'b0101_????: begin
                alu_s     = m_sum[15:0];
                alu_flags = {m_sum[16], 1'b0,
                             (~alu_a[15] & ~alu_b[15] & m_sum[15]) | (alu_a[15] & alu_b[15] & ~m_sum[15]),
                             m_sum[15:0] == 16'h0, m_sum[15]};
            end
            8'b0000_0110, 8'b0110_????: begin
                alu_s     = m_sum[15:0];
                alu_flags = {m_sum[16], 2'b00, m_sum[15:0] == 16'h0, m_sum[15]};
            end
            8'b0000_0001: begin
                alu_s     = alu_a & alu_b;
                alu_flags = {3'b000, (alu_a & alu_b) == 16'h0, alu_a[15] & alu_b[15]};
            end
            8'b1000_0000, 8'b1000_0100, 8'b1000_0110: begin
                alu_s     = {alu_a[14:0], 1'b0};
                alu_flags = {alu_a[15], 2'b00, alu_a[14:0] == 15'h0, alu_a[14]};
            end
            8'b1000_0001, 8'b1000_0101: begin
                alu_s     = {1'b0, alu_a[15:1]};
                alu_flags = {alu_a[0], 2'b00, alu_a[15:1] == 15'h0, 1'b0};
            end
            8'b1000_0111: begin
                alu_s     = {alu_a[15], alu_a[15:1]};
                alu_flags = {alu_a[0], 2'b00, {alu_a[15], alu_a[15:1]} == 16'h0, alu_a[15]};
            end
            8'b0000_1101, 8'b1101_????: begin
                alu_s = alu_a;
            end
            default: begin
                alu_s     = 16'h0000;
                alu_flags = 5'b00000;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request starting at a negedge; complete the response handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] ext,
                          input logic [15:0] a, input logic [15:0] b, input logic [7:0] exp_drive,
                          input int exp_lat, input logic [15:0] exp_data, input logic [4:0] exp_psr);
        int lat;
        bus.req_opcode = op;
        bus.req_opext  = ext;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, " ready_busy"}, 32'(bus.req_ready), 32'd0);
        check({tag, " drive"}, 32'({alu_opcode, alu_opext}), 32'(exp_drive));
        check({tag, " alu_a"}, 32'(alu_a), 32'(a));
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"}, 32'(bus.rsp_data), 32'(exp_data));
        check({tag, " psr"}, 32'(psr), 32'(exp_psr));
        check({tag, " done_drive"}, {8'h00, alu_opcode, alu_opext, alu_a}, 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, " release"}, 32'({bus.rsp_valid, bus.req_ready}), 32'd1);
    endtask

    initial begin
        int k;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_opcode = 4'h0;
        bus.req_opext = 4'h0;
        bus.req_a     = 16'h0;
        bus.req_b     = 16'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst psr", 32'(psr), 32'd0);
        check("rst drive", {alu_opcode, alu_opext, alu_a, 8'h00}, 32'd0);
        check("rst alu_b", 32'(alu_b), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("add",    4'b0000, 4'b0101, 16'h7FFF, 16'h0001, 8'h05, 2,  16'h8000, 5'b00101);
        run_op("addu",   4'b0000, 4'b0110, 16'hFFFF, 16'h0001, 8'h06, 2,  16'h0000, 5'b10010);
        run_op("addc",   4'b0000, 4'b0111, 16'h0001, 16'h0002, 8'h06, 3,  16'h0004, 5'b00000);
        run_op("lshi0",  4'b1000, 4'b0000, 16'h0001, 16'h0000, 8'h0D, 2,  16'h0001, 5'b00000);
        run_op("addcu",  4'b1010, 4'b0101, 16'hFFFF, 16'h0002, 8'h06, 2,  16'h0001, 5'b10000);
        run_op("addci",  4'b0111, 4'b0011, 16'h7FFF, 16'h0000, 8'h06, 3,  16'h8000, 5'b00100);
        run_op("lshi15", 4'b1000, 4'b0000, 16'h0001, 16'h000F, 8'h80, 16, 16'h8000, 5'b00001);
        run_op("arsh3",  4'b1000, 4'b0111, 16'h8000, 16'h0003, 8'h87, 4,  16'hF000, 5'b00001);
        run_op("add2",   4'b0000, 4'b0101, 16'h7FFF, 16'h0001, 8'h05, 2,  16'h8000, 5'b00101);
        run_op("mov",    4'b0000, 4'b1101, 16'h1234, 16'h5555, 8'h0D, 2,  16'h1234, 5'b00101);
        run_op("nop",    4'b0000, 4'b0000, 16'h0005, 16'h0006, 8'h00, 2,  16'h0000, 5'b00101);

        // Response back-pressure with a second request already waiting
        bus.req_opcode = 4'b0000;
        bus.req_opext  = 4'b0001;
        bus.req_a      = 16'h0F0F;
        bus.req_b      = 16'h00FF;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_a = 16'hAAAA;
        bus.req_b = 16'hF0FF;
        k = 0;
        while (!bus.rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold data", 32'(bus.rsp_data), 32'h000F);
            check("hold valid", 32'(bus.rsp_valid), 32'd1);
            check("hold no_accept", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        check("hold psr", 32'(psr), 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("hold idle_after_hs", 32'({bus.rsp_valid, bus.req_ready}), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("hold second_accept", 32'({bus.req_ready, alu_a}), 32'h0000AAAA);
        k = 0;
        while (!bus.rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("hold second_data", 32'(bus.rsp_data), 32'h0000A0AA);
        check("hold second_psr", 32'(psr), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Abort a 10-step shift with reset
        bus.req_opcode = 4'b1000;
        bus.req_opext  = 4'b0000;
        bus.req_a      = 16'h0001;
        bus.req_b      = 16'h000A;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort mid_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort mid_psr", 32'(psr), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort psr", 32'(psr), 32'd0);
        check("abort req_ready", 32'(bus.req_ready), 32'd1);
        check("abort drive", {alu_opcode, alu_opext, alu_a, 8'h00}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op("recover", 4'b0000, 4'b0110, 16'h0001, 16'h0001, 8'h06, 2, 16'h0002, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
